// File: rtl/bubble_sort_ctrl.sv
// Serial bubble-sort engine: loads N unsigned words, sorts them in place with one
// compare-exchange per clock, then streams them out in ascending order.
module bubble_sort_ctrl #(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int CW = $clog2(N) + 1;
  localparam int AW = $clog2(N);
  localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
  localparam logic [CW-1:0] LAST_PASS = CW'(N - 2);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  mem [N];
  logic [CW-1:0] wr_idx, rd_idx, j, pass;
  logic          swapped;

  logic [AW-1:0] wr_a, rd_a, ja, jb;
  logic [CW-1:0] last_j;
  logic          accept, xfer, do_swap, pass_end, sort_exit;

  assign wr_a     = wr_idx[AW-1:0];
  assign rd_a     = rd_idx[AW-1:0];
  assign ja       = j[AW-1:0];
  assign jb       = ja + AW'(1);
  assign last_j   = LAST_PASS - pass;
  // Strict compare keeps equal words in place, so the sort is stable.
  assign do_swap  = mem[ja] > mem[jb];
  assign pass_end = (j == last_j);
  assign sort_exit = pass_end && (!(swapped || do_swap) || (pass == LAST_PASS));
  assign out_data = mem[rd_a];

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    xfer      = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && (wr_idx == LAST_IDX)) state_nxt = SORT;
      end
      SORT: begin
        busy = 1'b1;
        if (sort_exit) state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        xfer      = out_ready;
        if (xfer && (rd_idx == LAST_IDX)) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx  <= '0;
      rd_idx  <= '0;
      j       <= '0;
      pass    <= '0;
      swapped <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx  <= '0;
              j       <= '0;
              pass    <= '0;
              swapped <= 1'b0;
            end else begin
              wr_idx <= wr_idx + CW'(1);
            end
          end
        end
        SORT: begin
          if (pass_end) begin
            pass    <= pass + CW'(1);
            j       <= '0;
            swapped <= 1'b0;
          end else begin
            j       <= j + CW'(1);
            swapped <= swapped | do_swap;
          end
        end
        DRAIN: begin
          if (xfer) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx <= '0;
              wr_idx <= '0;
            end else begin
              rd_idx <= rd_idx + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Word storage carries no reset; its contents only become visible in DRAIN.
  always_ff @(posedge clk) begin
    if (state == LOAD && accept) begin
      mem[wr_a] <= in_data;
    end else if (state == SORT && do_swap) begin
      mem[ja] <= mem[jb];
      mem[jb] <= mem[ja];
    end
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl: an N=8 instance for block tests and an
// N=2 instance for the minimal pair case.
module tb_bubble_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0] in_data, out_data;
  logic       p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_busy;
  logic [3:0] p_in_data, p_out_data;

  int checks = 0;
  int errors = 0;
  int slen;
  logic [3:0] blk  [8];
  logic [3:0] expv [8];

  bubble_sort_ctrl #(.N(8), .W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  bubble_sort_ctrl #(.N(2), .W(4)) u_pair (
    .clk(clk), .rst(rst),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
    .busy(p_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load8(input bit keep, input logic [3:0] next_data);
    for (int i = 0; i < 8; i++) begin
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      in_data  = blk[i];
      @(negedge clk);
    end
    in_valid = keep;
    in_data  = next_data;
  endtask

  task automatic sort_run(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drain8(input bit bp);
    int idx = 0;
    int t = 0;
    while (idx < 8 && t < 300) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("out_valid_drain", out_valid, 1);
      chk("out_data_drain", out_data, expv[idx]);
      chk("in_ready_drain", in_ready, 0);
      @(negedge clk);
      if (out_ready) idx++;
      t++;
    end
    out_ready = 1'b0;
    chk("drain_count", idx, 8);
    chk("in_ready_after_drain", in_ready, 1);
    chk("out_valid_after_drain", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    p_in_valid = 1'b0; p_in_data = '0; p_out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pair_in_ready", p_in_ready, 1);

    // N=2 pair: load {2,1}, one compare, output 1,2
    p_in_valid = 1'b1; p_in_data = 4'd2;
    @(negedge clk);
    p_in_data = 4'd1;
    @(negedge clk);
    p_in_valid = 1'b0;
    chk("pair_busy", p_busy, 1);
    @(negedge clk);
    chk("pair_busy_end", p_busy, 0);
    chk("pair_valid0", p_out_valid, 1);
    chk("pair_data0", p_out_data, 1);
    p_out_ready = 1'b1;
    @(negedge clk);
    chk("pair_valid1", p_out_valid, 1);
    chk("pair_data1", p_out_data, 2);
    @(negedge clk);
    p_out_ready = 1'b0;
    chk("pair_in_ready_after", p_in_ready, 1);
    chk("pair_out_valid_after", p_out_valid, 0);

    // Reverse input: 28 compares
    blk  = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
    expv = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    load8(1'b0, 4'd0);
    sort_run(slen);
    chk("sort_len_reverse", slen, 28);
    drain8(1'b0);

    // Duplicates and extreme values
    blk  = '{4'd3, 4'd0, 4'd15, 4'd3, 4'd7, 4'd0, 4'd15, 4'd1};
    expv = '{4'd0, 4'd0, 4'd1, 4'd3, 4'd3, 4'd7, 4'd15, 4'd15};
    load8(1'b0, 4'd0);
    sort_run(slen);
    drain8(1'b0);

    // Backpressure with in_valid held high; a stray accept would corrupt the next block
    blk  = '{4'd9, 4'd4, 4'd12, 4'd4, 4'd1, 4'd6, 4'd13, 4'd2};
    expv = '{4'd1, 4'd2, 4'd4, 4'd4, 4'd6, 4'd9, 4'd12, 4'd13};
    load8(1'b1, 4'd1);
    sort_run(slen);
    drain8(1'b1);

    // Already sorted: early exit after the first pass
    blk  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    expv = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    load8(1'b0, 4'd0);
    sort_run(slen);
    chk("sort_len_sorted", slen, 7);
    drain8(1'b0);

    // Reset during SORT cycle 5 of a reverse block
    blk = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
    load8(1'b0, 4'd0);
    repeat (4) @(negedge clk);
    chk("midreset_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_in_ready", in_ready, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_out_valid", out_valid, 0);

    blk  = '{4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    expv = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    load8(1'b0, 4'd0);
    sort_run(slen);
    chk("sort_len_after_reset", slen, 28);
    drain8(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
